// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//   Time-multiplexed LED matrix row scanner. Each row gets GAP_TICKS enable
//   ticks of blanking (so the previous row's column drive cannot ghost onto the
//   next row) followed by DWELL_TICKS ticks of drive. The pattern is latched
//   once per frame, on the blank->drive edge of row 0, so the display never
//   shows half of one pattern and half of another.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       scan tick; nothing advances on clocks where it is low
//   blank        forces outputs off in the same cycle, scan keeps running
//   segments     pattern, row r / column c at bit ROWS*COLS-1-(r*COLS+c)
//   rows         active-high row drive, row r at bit ROWS-1-r
//   cols         column drive, column c at bit COLS-1-c, polarity COL_ACTIVE_LOW
//   frame_start  one-clock pulse on the clock after each pattern capture
module led_matrix_scanner #(
  parameter int ROWS           = 3,
  parameter int COLS           = 3,
  parameter int DWELL_TICKS    = 1,
  parameter int GAP_TICKS      = 1,
  parameter int COL_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 blank,
  input  logic [ROWS*COLS-1:0] segments,
  output logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      cols,
  output logic                 frame_start
);

  localparam int N     = ROWS * COLS;
  localparam int MAXT  = (DWELL_TICKS > GAP_TICKS) ? DWELL_TICKS : GAP_TICKS;
  localparam int CNT_W = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int ROW_W = $clog2(ROWS);

  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [COLS-1:0]  COLS_OFF   = {COLS{COL_ACTIVE_LOW != 0}};

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [N-1:0]     fb_q, fb_d;
  logic             frame_start_q, frame_start_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      row_q         <= '0;
      fb_q          <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      fb_q          <= fb_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Next-state: everything holds unless enable is high.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    row_d         = row_q;
    fb_d          = fb_q;
    frame_start_d = 1'b0;
    if (enable) begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
            // Only the entry into row 0 latches a new pattern.
            if (row_q == '0) begin
              fb_d          = segments;
              frame_start_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end
  end

  // Output decode straight from registered state; blank gates combinationally.
  logic [ROWS-1:0] row_hot;
  logic [COLS-1:0] row_bits;
  logic            drive_on;

  always_comb begin
    row_hot  = '0;
    row_bits = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_q == ROW_W'(r)) begin
        row_hot[ROWS-1-r] = 1'b1;
        row_bits          = fb_q[N-1-r*COLS -: COLS];
      end
    end
    drive_on = (state_q == ST_DRIVE) && !blank;
    rows     = drive_on ? row_hot : '0;
    if (!drive_on)               cols = COLS_OFF;
    else if (COL_ACTIVE_LOW != 0) cols = ~row_bits;
    else                         cols = row_bits;
  end

  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: 3x3, DWELL=2, GAP=1. One instance
// uses active-low columns, a second uses active-high columns; both share
// clock, reset, enable and blank.
module tb_led_matrix_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       blank = 1'b0;
  logic [8:0] seg_lo = 9'b100010001;
  logic [8:0] seg_hi = 9'b101000101;
  logic [2:0] rows_lo, cols_lo, rows_hi, cols_hi;
  logic       fs_lo, fs_hi;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  led_matrix_scanner #(.ROWS(3), .COLS(3), .DWELL_TICKS(2), .GAP_TICKS(1),
                       .COL_ACTIVE_LOW(1)) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .enable(enable), .blank(blank),
    .segments(seg_lo), .rows(rows_lo), .cols(cols_lo), .frame_start(fs_lo));

  led_matrix_scanner #(.ROWS(3), .COLS(3), .DWELL_TICKS(2), .GAP_TICKS(1),
                       .COL_ACTIVE_LOW(0)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .enable(enable), .blank(blank),
    .segments(seg_hi), .rows(rows_hi), .cols(cols_hi), .frame_start(fs_hi));

  // One 9-clock frame, phase 0 = first clock after the row-0 capture edge.
  logic [2:0] exp_rows [9] = '{3'b100, 3'b100, 3'b000, 3'b010, 3'b010, 3'b000,
                               3'b001, 3'b001, 3'b000};
  // Pattern 100010001, active low: row0 ~100, row1 ~010, row2 ~001.
  logic [2:0] exp_cols_a [9] = '{3'b011, 3'b011, 3'b111, 3'b101, 3'b101, 3'b111,
                                 3'b110, 3'b110, 3'b111};
  // Pattern 111010111, active low: row0 ~111, row1 ~010, row2 ~111.
  logic [2:0] exp_cols_b [9] = '{3'b000, 3'b000, 3'b111, 3'b101, 3'b101, 3'b111,
                                 3'b000, 3'b000, 3'b111};
  // Pattern 101000101, active high; off is 000.
  logic [2:0] exp_cols_h [9] = '{3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000,
                                 3'b101, 3'b101, 3'b000};

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    seg_lo = 9'b100010001;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rows_lo, cols_lo, fs_lo} !== {3'b000, 3'b111, 1'b0})
      $display("FAIL reset_off: got rows=%b cols=%b fs=%b want 000 111 0", rows_lo, cols_lo, fs_lo);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if ({rows_lo, cols_lo, fs_lo, rows_hi, cols_hi} !== {3'b000, 3'b111, 1'b0, 3'b000, 3'b000})
      $display("FAIL reset_hold: got rows=%b cols=%b fs=%b hi rows=%b cols=%b", rows_lo, cols_lo, fs_lo, rows_hi, cols_hi);
    else n_pass++;
    rst_n = 1'b1;
    n_checks++;
    if ({rows_lo, cols_lo} !== {3'b000, 3'b111})
      $display("FAIL release_blank: got rows=%b cols=%b want 000 111", rows_lo, cols_lo);
    else n_pass++;
  endtask

  // Two frames from reset release; also checks the active-high instance.
  task automatic test_scan();
    for (int k = 0; k < 18; k++) begin
      tick();
      n_checks++;
      if ({rows_lo, cols_lo, fs_lo} !== {exp_rows[k%9], exp_cols_a[k%9], k%9 == 0})
        $display("FAIL scan k=%0d: got rows=%b cols=%b fs=%b want %b %b %b", k, rows_lo, cols_lo, fs_lo,
                 exp_rows[k%9], exp_cols_a[k%9], k%9 == 0);
      else n_pass++;
      n_checks++;
      if ({rows_hi, cols_hi, fs_hi} !== {exp_rows[k%9], exp_cols_h[k%9], k%9 == 0})
        $display("FAIL active_high k=%0d: got rows=%b cols=%b fs=%b want %b %b %b", k, rows_hi, cols_hi, fs_hi,
                 exp_rows[k%9], exp_cols_h[k%9], k%9 == 0);
      else n_pass++;
    end
  endtask

  // Continues straight after test_scan (next edge is phase 0).
  task automatic test_tear_free();
    for (int k = 0; k < 18; k++) begin
      tick();
      if (k < 9) begin
        n_checks++;
        if ({rows_lo, cols_lo, fs_lo} !== {exp_rows[k], exp_cols_a[k], k == 0})
          $display("FAIL tear_old k=%0d: got rows=%b cols=%b fs=%b want %b %b %b", k, rows_lo, cols_lo, fs_lo,
                   exp_rows[k], exp_cols_a[k], k == 0);
        else n_pass++;
        if (k == 3) seg_lo = 9'b111010111;  // row 1 currently driven
      end else begin
        n_checks++;
        if ({rows_lo, cols_lo, fs_lo} !== {exp_rows[k-9], exp_cols_b[k-9], k == 9})
          $display("FAIL tear_new k=%0d: got rows=%b cols=%b fs=%b want %b %b %b", k, rows_lo, cols_lo, fs_lo,
                   exp_rows[k-9], exp_cols_b[k-9], k == 9);
        else n_pass++;
      end
    end
  endtask

  task automatic test_enable();
    int n_en;
    logic [2:0] er, ec;
    logic       ef;
    seg_lo = 9'b100010001;
    do_reset();
    n_en = 0;
    for (int k = 0; k < 40; k++) begin
      enable = (k % 4 == 0);
      tick();
      if (enable) n_en++;
      er = exp_rows[(n_en-1)%9];
      ec = exp_cols_a[(n_en-1)%9];
      ef = enable && ((n_en-1) % 9 == 0);
      n_checks++;
      if ({rows_lo, cols_lo, fs_lo} !== {er, ec, ef})
        $display("FAIL enable_1in4 k=%0d: got rows=%b cols=%b fs=%b want %b %b %b", k, rows_lo, cols_lo, fs_lo, er, ec, ef);
      else n_pass++;
    end
    // n_en = 10 -> frozen at phase 0 (row 0 driven), no further pulse.
    enable = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if ({rows_lo, cols_lo, fs_lo} !== {3'b100, 3'b011, 1'b0})
        $display("FAIL enable_stuck k=%0d: got rows=%b cols=%b fs=%b want 100 011 0", k, rows_lo, cols_lo, fs_lo);
      else n_pass++;
    end
    enable = 1'b1;
  endtask

  task automatic test_blank();
    seg_lo = 9'b100010001;
    do_reset();
    tick();  // row 0 now driven
    blank = 1'b1;
    #1;
    n_checks++;
    if ({rows_lo, cols_lo} !== {3'b000, 3'b111})
      $display("FAIL blank_same_cycle: got rows=%b cols=%b want 000 111", rows_lo, cols_lo);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if ({rows_lo, cols_lo} !== {3'b000, 3'b111})
        $display("FAIL blank_hold k=%0d: got rows=%b cols=%b want 000 111", k, rows_lo, cols_lo);
      else n_pass++;
    end
    blank = 1'b0;
    tick();
    n_checks++;
    if ({rows_lo, cols_lo} !== {3'b010, 3'b101})
      $display("FAIL blank_row1_timing: got rows=%b cols=%b want 010 101", rows_lo, cols_lo);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    seg_lo = 9'b100010001;
    do_reset();
    for (int k = 0; k < 7; k++) tick();  // phase 6: row 2 driven
    n_checks++;
    if ({rows_lo, cols_lo} !== {3'b001, 3'b110})
      $display("FAIL mid_row2: got rows=%b cols=%b want 001 110", rows_lo, cols_lo);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rows_lo, cols_lo, fs_lo} !== {3'b000, 3'b111, 1'b0})
      $display("FAIL mid_reset_async: got rows=%b cols=%b fs=%b want 000 111 0", rows_lo, cols_lo, fs_lo);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      n_checks++;
      if ({rows_lo, cols_lo, fs_lo} !== {exp_rows[k], exp_cols_a[k], k == 0})
        $display("FAIL mid_restart k=%0d: got rows=%b cols=%b fs=%b want %b %b %b", k, rows_lo, cols_lo, fs_lo,
                 exp_rows[k], exp_cols_a[k], k == 0);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_enable();
    test_blank();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
